// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Converts debounced set-hours / set-minutes / fast-set levels into
// single-cycle increment pulses for the time counters. Each press produces one
// increment. With auto-repeat built, a held button repeats at the slow or fast
// set rate. o_setting is high while a set operation is in progress.
//
// Build option: define TIME_SET_AUTOREPEAT_EN to build hold-to-repeat
// (HOLD_WAIT/REPEAT). When it is left undefined, a press gives one pulse and
// the FSM then waits in WAIT_RELEASE for the selected button to be released.
//
// Parameters
//   HOLD_STB_COUNT    slow strobes a button must stay held before repeat (>=1)
// Ports
//   i_clk             system clock, all state on posedge
//   i_reset           asynchronous active-high reset
//   i_slow_set_stb    1-cycle slow set-rate strobe
//   i_fast_set_stb    1-cycle fast set-rate strobe
//   i_fast_set_db     debounced fast-set level
//   i_set_hours_db    debounced set-hours level
//   i_set_minutes_db  debounced set-minutes level
//   o_inc_hours       1-cycle pulse: increment hours
//   o_inc_minutes     1-cycle pulse: increment minutes
//   o_setting         high while the FSM is not IDLE
// ---------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int HOLD_STB_COUNT = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_slow_set_stb,
    input  logic i_fast_set_stb,
    input  logic i_fast_set_db,
    input  logic i_set_hours_db,
    input  logic i_set_minutes_db,
    output logic o_inc_hours,
    output logic o_inc_minutes,
    output logic o_setting
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOLD_WAIT    = 2'd1,
        REPEAT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic SEL_HOURS   = 1'b0;
    localparam logic SEL_MINUTES = 1'b1;

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam state_t PRESS_STATE = HOLD_WAIT;
    localparam int     CNT_W       = $clog2(HOLD_STB_COUNT + 1);
    // Value of hold_cnt when the strobe that completes the hold arrives.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_STB_COUNT - 1);

    logic [CNT_W-1:0] hold_cnt, next_cnt;
    logic             rate_stb;
`else
    localparam state_t PRESS_STATE = WAIT_RELEASE;

    // Rate inputs and the hold parameter have no role without auto-repeat.
    logic unused_cfg;
    assign unused_cfg = ^{i_slow_set_stb, i_fast_set_stb, i_fast_set_db,
                          (HOLD_STB_COUNT > 0)};
`endif

    state_t state, next_state;
    logic   sel, next_sel;
    logic   hours_prev, minutes_prev;
    logic   rise_hours, rise_minutes, sel_db;
    logic   inc_evt;
    logic   inc_hours_d, inc_minutes_d, setting_d;

    assign rise_hours   = i_set_hours_db   & ~hours_prev;
    assign rise_minutes = i_set_minutes_db & ~minutes_prev;
    assign sel_db       = (sel == SEL_MINUTES) ? i_set_minutes_db : i_set_hours_db;

`ifdef TIME_SET_AUTOREPEAT_EN
    // fast-set level is sampled every cycle, so it may change mid-repeat
    assign rate_stb = i_fast_set_db ? i_fast_set_stb : i_slow_set_stb;
`endif

    // State register, edge history and registered outputs.
    // History resets to 1 so a button already held at reset release is not a press.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            sel           <= SEL_HOURS;
            hours_prev    <= 1'b1;
            minutes_prev  <= 1'b1;
            o_inc_hours   <= 1'b0;
            o_inc_minutes <= 1'b0;
            o_setting     <= 1'b0;
`ifdef TIME_SET_AUTOREPEAT_EN
            hold_cnt      <= '0;
`endif
        end else begin
            state         <= next_state;
            sel           <= next_sel;
            hours_prev    <= i_set_hours_db;
            minutes_prev  <= i_set_minutes_db;
            o_inc_hours   <= inc_hours_d;
            o_inc_minutes <= inc_minutes_d;
            o_setting     <= setting_d;
`ifdef TIME_SET_AUTOREPEAT_EN
            hold_cnt      <= next_cnt;
`endif
        end
    end

    // Next-state logic. Release is tested before any strobe so a release
    // coinciding with a strobe yields no pulse.
    always_comb begin
        next_state = state;
        next_sel   = sel;
        inc_evt    = 1'b0;
`ifdef TIME_SET_AUTOREPEAT_EN
        next_cnt   = hold_cnt;
`endif
        case (state)
            IDLE: begin
                // hours has priority; a coincident minutes rise is dropped
                if (rise_hours) begin
                    next_sel   = SEL_HOURS;
                    next_state = PRESS_STATE;
                    inc_evt    = 1'b1;
                end else if (rise_minutes) begin
                    next_sel   = SEL_MINUTES;
                    next_state = PRESS_STATE;
                    inc_evt    = 1'b1;
                end
            end
`ifdef TIME_SET_AUTOREPEAT_EN
            HOLD_WAIT: begin
                if (!sel_db) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (i_slow_set_stb) begin
                    if (hold_cnt == CNT_LAST) begin
                        next_state = REPEAT;
                        next_cnt   = '0;
                        inc_evt    = 1'b1;
                    end else begin
                        next_cnt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!sel_db) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (rate_stb) begin
                    inc_evt = 1'b1;
                end
            end
`else
            WAIT_RELEASE: begin
                if (!sel_db)
                    next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Output decode, registered above so pulses and o_setting share latency.
    always_comb begin
        inc_hours_d   = inc_evt & (next_sel == SEL_HOURS);
        inc_minutes_d = inc_evt & (next_sel == SEL_MINUTES);
        setting_d     = (next_state != IDLE);
    end

endmodule
